vga_box_gen: RTL and testbench

Pixel generator that sits directly downstream of the VGA sync counter. It consumes `pixel_x`/`pixel_y`/`video_on`/`p_tick` and the sync pulses, and draws a square box that bounces around the visible area; colour, speed, pause and background are set from board switches. Output RGB and sync run through a two-stage pipeline, so colour and sync arrive at the connector aligned.

---
 rtl/vga_box_gen_if.sv | 36 +++
 rtl/vga_box_gen.sv | 211 +++++++++++++++++++++
 tb/tb_vga_box_gen.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_box_gen_if.sv
// ---------------------------------------------------------------------------
// vga_box_gen_if
//   Pixel-stream bundle between a VGA sync counter and the box generator.
//   Timing side (driven by the sync counter / master):
//     p_tick    pixel enable, one clk wide, every second cycle
//     video_on  high while (pixel_x, pixel_y) is in the visible area
//     hsync_in  horizontal sync from the counter
//     vsync_in  vertical sync from the counter
//     pixel_x   current column, 0..799
//     pixel_y   current line, 0..524
//   Connector side (driven by the box generator / slave):
//     hsync     hsync_in delayed two pixel ticks
//     vsync     vsync_in delayed two pixel ticks
//     rgb       4:4:4 colour, [11:8] R, [7:4] G, [3:0] B
// ---------------------------------------------------------------------------
interface vga_box_gen_if;
  logic        p_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;

  modport master (
    output p_tick, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
    input  hsync, vsync, rgb
  );

  modport slave (
    input  p_tick, video_on, hsync_in, vsync_in, pixel_x, pixel_y,
    output hsync, vsync, rgb
  );
endinterface

// File: rtl/vga_box_gen.sv
// ---------------------------------------------------------------------------
// vga_box_gen
//   Draws a square box that bounces around the visible area. The box moves
//   once per frame, at the start of vertical blanking, so a frame never tears.
//   Colour and sync go through a two-stage pipeline clocked on p_tick, which
//   keeps rgb aligned with hsync/vsync at the connector.
//
// Ports
//   clk         system clock, shared with the sync counter
//   rst         asynchronous, active-low reset
//   sw[2:0]     box colour R,G,B (each bit drives a full 4-bit channel)
//   sw[5:3]     speed, 0..7 pixels per frame
//   sw[6]       pause (no movement, no frame_tick)
//   sw[7]       grey background enable
//   frame_tick  one-clk pulse when the box position updates
//   vga         pixel-stream bundle (slave side), see vga_box_gen_if
//
// Build option
//   VGA_BOX_BORDER_EN  when defined, box perimeter pixels render white and
//                      the interior renders the switch colour. When not
//                      defined the whole box renders the switch colour.
// ---------------------------------------------------------------------------
module vga_box_gen #(
  parameter int HD       = 640,
  parameter int VD       = 480,
  parameter int BOX_SIZE = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   sw,
  output logic         frame_tick,
  vga_box_gen_if.slave vga
);

  // All position arithmetic is 11 bits wide so sums never wrap.
  localparam logic [10:0] BOX   = 11'(BOX_SIZE);
  localparam logic [10:0] X_MAX = 11'(HD - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(VD - BOX_SIZE);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;  // 1 = moving +, 0 = moving -
  } axis_t;

  // One axis step: clamp at the far edge or at zero and reverse there.
  // Landing exactly on an edge keeps the direction; the flip happens on the
  // following step when the move would overshoot.
  function automatic axis_t step_axis(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [2:0]  spd,
                                      input logic [10:0] max);
    axis_t       res;
    logic [10:0] sum;
    sum     = {1'b0, pos} + {8'd0, spd};
    res.pos = pos;
    res.dir = dir;
    if (dir) begin
      if (sum > max) begin
        res.pos = max[9:0];
        res.dir = 1'b0;
      end else begin
        res.pos = sum[9:0];
      end
    end else begin
      if ({7'd0, spd} > pos) begin
        res.pos = '0;
        res.dir = 1'b1;
      end else begin
        res.pos = pos - {7'd0, spd};
      end
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Box motion
  // -------------------------------------------------------------------------
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       dir_x;
  logic       dir_y;
  logic       upd;
  axis_t      next_x;
  axis_t      next_y;

  // First pixel of the first blanking line: once per frame.
  assign upd = vga.p_tick && (vga.pixel_x == 10'd0) && (vga.pixel_y == 10'(VD));

  always_comb begin
    next_x = step_axis(box_x, dir_x, sw[5:3], X_MAX);
    next_y = step_axis(box_y, dir_y, sw[5:3], Y_MAX);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x      <= '0;
      box_y      <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (upd && !sw[6]) begin
        frame_tick <= 1'b1;
        box_x      <= next_x.pos;
        dir_x      <= next_x.dir;
        box_y      <= next_y.pos;
        dir_y      <= next_y.dir;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: hit test and sideband capture
  // -------------------------------------------------------------------------
  logic [10:0] px;
  logic [10:0] py;
  logic [10:0] bx;
  logic [10:0] by;
  logic        in_box;

  assign px = {1'b0, vga.pixel_x};
  assign py = {1'b0, vga.pixel_y};
  assign bx = {1'b0, box_x};
  assign by = {1'b0, box_y};

  assign in_box = vga.video_on &&
                  (px >= bx) && (px < bx + BOX) &&
                  (py >= by) && (py < by + BOX);

  logic       hit_q;
  logic       vis_q;
  logic       hs_q;
  logic       vs_q;
  logic [2:0] col_q;
  logic       bg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q <= 1'b0;
      vis_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      col_q <= '0;
      bg_q  <= 1'b0;
    end else if (vga.p_tick) begin
      hit_q <= in_box;
      vis_q <= vga.video_on;
      hs_q  <= vga.hsync_in;
      vs_q  <= vga.vsync_in;
      col_q <= sw[2:0];
      bg_q  <= sw[7];
    end
  end

`ifdef VGA_BOX_BORDER_EN
  logic on_perim;
  logic perim_q;

  assign on_perim = in_box &&
                    ((px == bx) || (px == bx + BOX - 11'd1) ||
                     (py == by) || (py == by + BOX - 11'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perim_q <= 1'b0;
    end else if (vga.p_tick) begin
      perim_q <= on_perim;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Stage 2: colour select and output registers
  // -------------------------------------------------------------------------
  logic [11:0] box_rgb;
  logic [11:0] rgb_d;

  assign box_rgb = {{4{col_q[2]}}, {4{col_q[1]}}, {4{col_q[0]}}};

  // NOTE: rgb_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rgb_d = 12'h000;
    if (hit_q) begin
`ifdef VGA_BOX_BORDER_EN
      rgb_d = perim_q ? 12'hFFF : box_rgb;
`else
      rgb_d = box_rgb;
`endif
    end else if (vis_q && bg_q) begin
      rgb_d = 12'h888;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga.rgb   <= '0;
      vga.hsync <= 1'b0;
      vga.vsync <= 1'b0;
    end else if (vga.p_tick) begin
      vga.rgb   <= rgb_d;
      vga.hsync <= hs_q;
      vga.vsync <= vs_q;
    end
  end

endmodule

// File: tb/tb_vga_box_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_box_gen
//   Directed bench for vga_box_gen. The bench plays the sync counter: it
//   drives single pixel ticks (two clk each) with chosen coordinates rather
//   than sweeping whole frames, and fires the per-frame update by presenting
//   pixel (0, VD) with p_tick. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_box_gen;
  localparam int HD  = 640;
  localparam int VD  = 480;
  localparam int BOX = 32;

`ifdef VGA_BOX_BORDER_EN
  localparam logic [11:0] RED_EDGE = 12'hFFF;
`else
  localparam logic [11:0] RED_EDGE = 12'hF00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       frame_tick;

  vga_box_gen_if vif ();

  vga_box_gen #(.HD(HD), .VD(VD), .BOX_SIZE(BOX)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .frame_tick (frame_tick),
    .vga        (vif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // One pixel tick: inputs presented with p_tick for one clk, then one idle clk.
  task automatic tick(input int x, input int y, input logic von,
                      input logic hs, input logic vs);
    @(negedge clk);
    vif.pixel_x  = 10'(x);
    vif.pixel_y  = 10'(y);
    vif.video_on = von;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    vif.p_tick   = 1'b1;
    @(negedge clk);
    vif.p_tick   = 1'b0;
  endtask

  // Present a pixel, then a blanking filler tick so it reaches rgb.
  task automatic show(input int x, input int y, input logic von);
    tick(x, y, von, 1'b0, 1'b0);
    tick(HD + 10, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Present the update pixel with switches s applied on the same edge.
  task automatic update(input logic [7:0] s, output logic ft);
    @(negedge clk);
    sw           = s;
    vif.pixel_x  = 10'd0;
    vif.pixel_y  = 10'(VD);
    vif.video_on = 1'b0;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    vif.p_tick   = 1'b1;
    @(negedge clk);
    ft         = frame_tick;
    vif.p_tick = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst          = 1'b0;
    sw           = '0;
    vif.p_tick   = 1'b0;
    vif.video_on = 1'b0;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    vif.pixel_x  = '0;
    vif.pixel_y  = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({vif.rgb, vif.hsync, vif.vsync, frame_tick} !== 15'd0) begin
      $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b ft=%b, want all 0",
               vif.rgb, vif.hsync, vif.vsync, frame_tick);
    end else passed++;
    total++;
    if ({dut.box_x, dut.box_y, dut.dir_x, dut.dir_y} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      $display("FAIL reset_box: got (%0d,%0d) dir %b%b, want (0,0) dir 11",
               dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
    end else passed++;
    rst = 1'b1;
  endtask

  task automatic test_first_frame();
    logic ft;
    update(8'b0_0_001_111, ft);
    total++;
    if (ft !== 1'b1) $display("FAIL first_ft: got %b, want 1", ft);
    else passed++;
    total++;
    if ({dut.box_x, dut.box_y, dut.dir_x, dut.dir_y} !== {10'd1, 10'd1, 1'b1, 1'b1}) begin
      $display("FAIL first_box: got (%0d,%0d) dir %b%b, want (1,1) dir 11",
               dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
    end else passed++;
    @(negedge clk);
    total++;
    if (frame_tick !== 1'b0) $display("FAIL ft_width: got %b one clk later, want 0", frame_tick);
    else passed++;
    show(1, 1, 1'b1);
    total++;
    if (vif.rgb !== 12'hFFF) $display("FAIL pix_1_1: got %h, want fff", vif.rgb);
    else passed++;
    show(0, 0, 1'b1);
    total++;
    if (vif.rgb !== 12'h000) $display("FAIL pix_0_0: got %h, want 000", vif.rgb);
    else passed++;
    show(32, 32, 1'b1);
    total++;
    if (vif.rgb !== 12'hFFF) $display("FAIL pix_32_32: got %h, want fff", vif.rgb);
    else passed++;
    show(33, 1, 1'b1);
    total++;
    if (vif.rgb !== 12'h000) $display("FAIL pix_33_1: got %h, want 000", vif.rgb);
    else passed++;
  endtask

  task automatic test_pause();
    logic ft;
    for (int i = 0; i < 3; i++) begin
      update(8'b0_1_001_111, ft);
      total++;
      if (ft !== 1'b0) $display("FAIL pause_ft%0d: got %b, want 0", i, ft);
      else passed++;
    end
    total++;
    if ({dut.box_x, dut.box_y} !== {10'd1, 10'd1}) begin
      $display("FAIL pause_box: got (%0d,%0d), want (1,1)", dut.box_x, dut.box_y);
    end else passed++;
    update(8'b0_0_001_111, ft);
    total++;
    if (ft !== 1'b1) $display("FAIL resume_ft: got %b, want 1", ft);
    else passed++;
    total++;
    if ({dut.box_x, dut.box_y} !== {10'd2, 10'd2}) begin
      $display("FAIL resume_box: got (%0d,%0d), want (2,2)", dut.box_x, dut.box_y);
    end else passed++;
  endtask

  task automatic test_speed_zero_and_switch();
    logic ft;
    update(8'b0_0_000_111, ft);
    total++;
    if (ft !== 1'b1) $display("FAIL s0_ft: got %b, want 1", ft);
    else passed++;
    total++;
    if ({dut.box_x, dut.box_y, dut.dir_x, dut.dir_y} !== {10'd2, 10'd2, 1'b1, 1'b1}) begin
      $display("FAIL s0_box: got (%0d,%0d) dir %b%b, want (2,2) dir 11",
               dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
    end else passed++;
    // Speed changes to 3 on the very edge of the update: 3 is used.
    update(8'b0_0_011_111, ft);
    @(negedge clk);
    sw = 8'b0_0_000_111;
    total++;
    if ({dut.box_x, dut.box_y} !== {10'd5, 10'd5}) begin
      $display("FAIL sw_at_upd: got (%0d,%0d), want (5,5)", dut.box_x, dut.box_y);
    end else passed++;
  endtask

  task automatic test_speed_bounce();
    logic ft;
    int   ex, ey;
    logic edx, edy, found;
    pulse_reset();
    for (int n = 1; n <= 131; n++) begin
      update(8'b0_0_111_000, ft);
      total++;
      if (ft !== 1'b1) $display("FAIL bounce_ft%0d: got %b, want 1", n, ft);
      else passed++;
      found = 1'b1;
      ex = 0; ey = 0; edx = 1'b1; edy = 1'b1;
      case (n)
        64:  begin ex = 448; ey = 448; edx = 1'b1; edy = 1'b1; end
        65:  begin ex = 455; ey = 448; edx = 1'b1; edy = 1'b0; end
        66:  begin ex = 462; ey = 441; edx = 1'b1; edy = 1'b0; end
        85:  begin ex = 595; ey = 308; edx = 1'b1; edy = 1'b0; end
        86:  begin ex = 602; ey = 301; edx = 1'b1; edy = 1'b0; end
        87:  begin ex = 608; ey = 294; edx = 1'b0; edy = 1'b0; end
        88:  begin ex = 601; ey = 287; edx = 1'b0; edy = 1'b0; end
        129: begin ex = 314; ey = 0;   edx = 1'b0; edy = 1'b0; end
        130: begin ex = 307; ey = 0;   edx = 1'b0; edy = 1'b1; end
        131: begin ex = 300; ey = 7;   edx = 1'b0; edy = 1'b1; end
        default: found = 1'b0;
      endcase
      if (found) begin
        total++;
        if ({dut.box_x, dut.box_y, dut.dir_x, dut.dir_y} !==
            {10'(ex), 10'(ey), edx, edy}) begin
          $display("FAIL bounce_%0d: got (%0d,%0d) dir %b%b, want (%0d,%0d) dir %b%b",
                   n, dut.box_x, dut.box_y, dut.dir_x, dut.dir_y, ex, ey, edx, edy);
        end else passed++;
      end
    end
  endtask

  task automatic test_background_sync();
    // Box paused at (300,7), colour 0, grey background on.
    sw = 8'b1_1_000_000;
    show(0, 0, 1'b1);
    total++;
    if (vif.rgb !== 12'h888) $display("FAIL bg_visible: got %h, want 888", vif.rgb);
    else passed++;
    show(310, 10, 1'b1);
    total++;
    if (vif.rgb !== 12'h000) $display("FAIL bg_box_black: got %h, want 000", vif.rgb);
    else passed++;
    show(700, 10, 1'b0);
    total++;
    if (vif.rgb !== 12'h000) $display("FAIL bg_blank: got %h, want 000", vif.rgb);
    else passed++;
    tick(700, 490, 1'b0, 1'b1, 1'b1);
    total++;
    if ({vif.hsync, vif.vsync} !== 2'b00) begin
      $display("FAIL sync_lag1: got %b%b after 1 tick, want 00", vif.hsync, vif.vsync);
    end else passed++;
    @(negedge clk);
    total++;
    if ({vif.hsync, vif.vsync} !== 2'b00) begin
      $display("FAIL sync_idle: got %b%b on idle clk, want 00", vif.hsync, vif.vsync);
    end else passed++;
    tick(701, 490, 1'b0, 1'b0, 1'b0);
    total++;
    if ({vif.hsync, vif.vsync} !== 2'b11) begin
      $display("FAIL sync_lag2: got %b%b after 2 ticks, want 11", vif.hsync, vif.vsync);
    end else passed++;
    tick(702, 490, 1'b0, 1'b0, 1'b0);
    total++;
    if ({vif.hsync, vif.vsync} !== 2'b00) begin
      $display("FAIL sync_fall: got %b%b, want 00", vif.hsync, vif.vsync);
    end else passed++;
  endtask

  task automatic test_border();
    logic ft;
    pulse_reset();
    update(8'b0_0_001_100, ft);
    sw = 8'b0_1_000_100;
    show(1, 1, 1'b1);
    total++;
    if (vif.rgb !== RED_EDGE) $display("FAIL corner: got %h, want %h", vif.rgb, RED_EDGE);
    else passed++;
    show(6, 6, 1'b1);
    total++;
    if (vif.rgb !== 12'hF00) $display("FAIL interior: got %h, want f00", vif.rgb);
    else passed++;
    show(10, 1, 1'b1);
    total++;
    if (vif.rgb !== RED_EDGE) $display("FAIL top_edge: got %h, want %h", vif.rgb, RED_EDGE);
    else passed++;
    show(32, 20, 1'b1);
    total++;
    if (vif.rgb !== RED_EDGE) $display("FAIL right_edge: got %h, want %h", vif.rgb, RED_EDGE);
    else passed++;
    show(31, 20, 1'b1);
    total++;
    if (vif.rgb !== 12'hF00) $display("FAIL near_right: got %h, want f00", vif.rgb);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    logic ft;
    tick(5, 5, 1'b1, 1'b1, 1'b1);
    tick(5, 5, 1'b1, 1'b1, 1'b1);
    total++;
    if ({vif.rgb, vif.hsync, vif.vsync} !== {12'hF00, 1'b1, 1'b1}) begin
      $display("FAIL pre_reset: got rgb=%h hs=%b vs=%b, want f00 1 1",
               vif.rgb, vif.hsync, vif.vsync);
    end else passed++;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({vif.rgb, vif.hsync, vif.vsync, frame_tick} !== 15'd0) begin
      $display("FAIL async_reset: got rgb=%h hs=%b vs=%b ft=%b, want all 0",
               vif.rgb, vif.hsync, vif.vsync, frame_tick);
    end else passed++;
    total++;
    if ({dut.box_x, dut.box_y, dut.dir_x, dut.dir_y} !== {10'd0, 10'd0, 1'b1, 1'b1}) begin
      $display("FAIL async_reset_box: got (%0d,%0d) dir %b%b, want (0,0) dir 11",
               dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
    end else passed++;
    @(negedge clk);
    rst = 1'b1;
    update(8'b0_0_001_100, ft);
    total++;
    if ({ft, dut.box_x, dut.box_y} !== {1'b1, 10'd1, 10'd1}) begin
      $display("FAIL post_reset_upd: got ft=%b (%0d,%0d), want ft=1 (1,1)",
               ft, dut.box_x, dut.box_y);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_pause();
    test_speed_zero_and_switch();
    test_speed_bounce();
    test_background_sync();
    test_border();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
